// File: rtl/int_to_float.sv
// Multi-cycle 32-bit integer (signed or unsigned) to IEEE-754 single-precision converter.
// Normalises one bit per cycle, then rounds to nearest-even; start/done handshake.
module int_to_float #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic        is_signed,
  output logic [31:0] z,
  output logic        done,
  output logic        busy,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  localparam logic [7:0] EXP_SEED = 8'(EXP_BIAS + 31);

  state_t      state;
  logic [31:0] mag;
  logic [7:0]  exp_q;
  logic        sign_q;

  logic        in_sign;
  logic [31:0] in_mag;
  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic        carry;
  logic [22:0] frac_inc;
  logic [22:0] frac_rounded;

  // -2^31 negates to 0x80000000, which is the correct unsigned magnitude
  assign in_sign = is_signed & a[31];
  assign in_mag  = in_sign ? (~a + 32'd1) : a;

  // Once mag[31] is set, bit 31 is the hidden one and the next 23 bits are the fraction
  assign frac         = mag[30:8];
  assign guard        = mag[7];
  assign sticky       = |mag[6:0];
  assign round_up     = guard & (sticky | frac[0]);
  assign frac_inc     = frac + 23'd1;
  assign carry        = round_up & (&frac);
  assign frac_rounded = round_up ? frac_inc : frac;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      z       <= 32'd0;
      done    <= 1'b0;
      inexact <= 1'b0;
      mag     <= 32'd0;
      exp_q   <= 8'd0;
      sign_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (in_mag == 32'd0) begin
              z       <= 32'd0;
              inexact <= 1'b0;
              done    <= 1'b1;
            end else begin
              mag    <= in_mag;
              sign_q <= in_sign;
              exp_q  <= EXP_SEED;
              state  <= NORM;
            end
          end
        end
        NORM: begin
          if (!mag[31]) begin
            mag   <= mag << 1;
            exp_q <= exp_q - 8'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          // A fraction carry bumps the exponent; the largest reachable value is 159
          z       <= {sign_q, exp_q + {7'd0, carry}, frac_rounded};
          inexact <= guard | sticky;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
